// File: rtl/rotate_sequencer.sv
// Rotate sequencer: fetches a 24-bit move order word from an external
// register file and applies up to six face moves, one nibble at a time.
// Faces are rotated or partially swapped through the register-file ports.
// The three faces are then compared against three ideal registers, and the
// result is reported as solved.
module rotate_sequencer #(
    parameter logic [3:0] ORDER_REG  = 4'd6,
    parameter logic [3:0] FACE_BASE  = 4'd0,
    parameter logic [3:0] IDEAL_BASE = 4'd9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [3:0]  src0,
    output logic [3:0]  src1,
    input  logic [23:0] data0,
    input  logic [23:0] data1,
    output logic [3:0]  dst,
    output logic        we,
    output logic [23:0] data,
    output logic        busy,
    output logic        done,
    output logic        solved,
    output logic [2:0]  move_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_READ,
        S_WB0,
        S_WB1,
        S_CMP,
        S_DONE
    } state_e;

    // Classification of one order nibble.
    typedef enum logic [1:0] {
        K_NOP,
        K_ROT,
        K_SWAP,
        K_END
    } kind_e;

    localparam logic [2:0] LAST_MOVE = 3'd6;

    state_e      state_q, state_d;
    logic [23:0] order_q, order_d;
    logic [23:0] opa_q, opa_d;
    logic [23:0] opb_q, opb_d;
    logic [2:0]  move_cnt_q, move_cnt_d;
    logic [1:0]  cmp_k_q, cmp_k_d;
    logic        match_q, match_d;
    logic        solved_q, solved_d;

    logic [3:0]  cur_code;
    kind_e       kind;
    logic [3:0]  off_a;
    logic [3:0]  off_b;
    logic [2:0]  cnt_inc;
    state_e      adv_state;

    // Nibble idx of the order word, most significant nibble first.
    function automatic logic [3:0] nibble_at(input logic [23:0] word,
                                             input logic [2:0]  idx);
        logic [3:0] nib;
        case (idx)
            3'd0:    nib = word[23:20];
            3'd1:    nib = word[19:16];
            3'd2:    nib = word[15:12];
            3'd3:    nib = word[11:8];
            3'd4:    nib = word[7:4];
            3'd5:    nib = word[3:0];
            default: nib = 4'h0;
        endcase
        return nib;
    endfunction

    // Rotate left by one nibble.
    function automatic logic [23:0] rotl4(input logic [23:0] x);
        return {x[19:0], x[23:20]};
    endfunction

    // Decode the current nibble into a move kind and the face offsets it touches.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first, so no path can infer a latch.
        cur_code = nibble_at(order_q, move_cnt_q);
        kind     = K_NOP;
        off_a    = 4'd0;
        off_b    = 4'd0;
        case (cur_code)
            4'h1: begin kind = K_ROT;  off_a = 4'd0; off_b = 4'd0; end
            4'h2: begin kind = K_ROT;  off_a = 4'd1; off_b = 4'd1; end
            4'h3: begin kind = K_ROT;  off_a = 4'd2; off_b = 4'd2; end
            4'h4: begin kind = K_SWAP; off_a = 4'd0; off_b = 4'd1; end
            4'h5: begin kind = K_SWAP; off_a = 4'd1; off_b = 4'd2; end
            4'h6: begin kind = K_SWAP; off_a = 4'd2; off_b = 4'd0; end
            4'hF: begin kind = K_END; end
            default: begin kind = K_NOP; end
        endcase
    end

    // Advance to the next nibble. After the sixth nibble, go to the compare phase.
    always_comb begin
        cnt_inc   = move_cnt_q + 3'd1;
        adv_state = (cnt_inc == LAST_MOVE) ? S_CMP : S_READ;
    end

    // Compute the next state, the datapath next values and all outputs.
    always_comb begin
        state_d    = state_q;
        order_d    = order_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        move_cnt_d = move_cnt_q;
        cmp_k_d    = cmp_k_q;
        match_d    = match_q;
        solved_d   = solved_q;
        src0       = 4'd0;
        src1       = 4'd0;
        dst        = 4'd0;
        we         = 1'b0;
        data       = 24'd0;
        done       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                src0       = ORDER_REG;
                order_d    = data0;
                move_cnt_d = 3'd0;
                cmp_k_d    = 2'd0;
                match_d    = 1'b1;
                state_d    = S_READ;
            end

            S_READ: begin
                if (kind == K_ROT || kind == K_SWAP) begin
                    src0 = FACE_BASE + off_a;
                    src1 = FACE_BASE + off_b;
                end
                opa_d = data0;
                opb_d = data1;
                case (kind)
                    K_ROT, K_SWAP: state_d = S_WB0;
                    K_END:         state_d = S_CMP;
                    default: begin
                        move_cnt_d = cnt_inc;
                        state_d    = adv_state;
                    end
                endcase
            end

            S_WB0: begin
                we  = 1'b1;
                dst = FACE_BASE + off_a;
                if (kind == K_SWAP) begin
                    data    = {opb_q[23:20], opa_q[19:0]};
                    state_d = S_WB1;
                end else begin
                    data       = rotl4(opa_q);
                    move_cnt_d = cnt_inc;
                    state_d    = adv_state;
                end
            end

            S_WB1: begin
                we         = 1'b1;
                dst        = FACE_BASE + off_b;
                data       = {opa_q[23:20], opb_q[19:0]};
                move_cnt_d = cnt_inc;
                state_d    = adv_state;
            end

            S_CMP: begin
                src0    = FACE_BASE + {2'b00, cmp_k_q};
                src1    = IDEAL_BASE + {2'b00, cmp_k_q};
                match_d = match_q & (data0 == data1);
                cmp_k_d = cmp_k_q + 2'd1;
                if (cmp_k_q == 2'd2) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                done     = 1'b1;
                solved_d = match_q;
                state_d  = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Register the state and the datapath. Reset aborts a run at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every register here is a plain flop, so all of them are reset; there is no storage array to exclude.
            state_q    <= S_IDLE;
            order_q    <= 24'd0;
            opa_q      <= 24'd0;
            opb_q      <= 24'd0;
            move_cnt_q <= 3'd0;
            cmp_k_q    <= 2'd0;
            match_q    <= 1'b0;
            solved_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the same pre-edge values.
            state_q    <= state_d;
            order_q    <= order_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            move_cnt_q <= move_cnt_d;
            cmp_k_q    <= cmp_k_d;
            match_q    <= match_d;
            solved_q   <= solved_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign solved   = solved_q;
    assign move_cnt = move_cnt_q;

endmodule

// File: tb/tb_rotate_sequencer.sv
// Testbench for rotate_sequencer.
// The bench models the register file. A reference model works out each
// run's writes, final faces, latency, final move index and solved flag
// directly from the move rules.
module tb_rotate_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  src0, src1, dst;
    logic [23:0] data0, data1, data;
    logic        we, busy, done, solved;
    logic [2:0]  move_cnt;

    always #5 clk = ~clk;

    rotate_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .src0     (src0),
        .src1     (src1),
        .data0    (data0),
        .data1    (data1),
        .dst      (dst),
        .we       (we),
        .data     (data),
        .busy     (busy),
        .done     (done),
        .solved   (solved),
        .move_cnt (move_cnt)
    );

    // Register file with combinational reads. Writes land on the rising edge.
    logic [23:0] rf [16];
    logic        ld_en = 1'b0;
    logic [3:0]  ld_addr = 4'd0;
    logic [23:0] ld_data = 24'd0;

    assign data0 = rf[src0];
    assign data1 = rf[src1];

    always @(posedge clk) begin
        if (ld_en) rf[ld_addr] <= ld_data;
        else if (we) rf[dst] <= data;
    end

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int          t;
        logic [3:0]  a;
        logic [23:0] d;
    } wr_t;

    wr_t wlog[$];
    int  run_base;
    int  run_lat;

    // Log every write. Also check that data is zero whenever we is low,
    // and that the read addresses are zero in IDLE and DONE.
    always @(negedge clk) begin
        if (we) wlog.push_back('{cyc, dst, data});
        if (!we) begin
            checks++;
            if (data !== 24'd0) begin
                errors++;
                $display("FAIL data_when_idle: data=%h required 000000 at cycle %0d", data, cyc);
            end
        end
        if (!busy || done) begin
            checks++;
            if (src0 !== 4'd0 || src1 !== 4'd0) begin
                errors++;
                $display("FAIL src_idle: src0=%0d src1=%0d required 0 at cycle %0d", src0, src1, cyc);
            end
        end
    end

    // ---------------- reference model ----------------
    logic [23:0] m_face[3];
    wr_t         m_writes[$];
    int          m_lat;
    int          m_cnt;
    bit          m_solved;

    // Work out the expected run, cycle by cycle. FETCH is cycle 1, each READ
    // and each write-back take one cycle, and they are followed by 3 CMP
    // cycles and 1 DONE cycle.
    task automatic model(input logic [23:0] f0, f1, f2, input logic [23:0] order);
        int face[3];
        int t, code, a, b, na, nb;
        face[0] = int'(f0);
        face[1] = int'(f1);
        face[2] = int'(f2);
        m_writes.delete();
        t = 1;
        m_cnt = 6;
        for (int i = 0; i < 6; i++) begin
            code = (int'(order) >> (20 - 4 * i)) & 15;
            t++;
            if (code == 15) begin
                m_cnt = i;
                break;
            end
            if (code >= 1 && code <= 3) begin
                a = code - 1;
                face[a] = ((face[a] << 4) | (face[a] >> 20)) & 'hFFFFFF;
                t++;
                m_writes.push_back('{t, 4'(a), 24'(face[a])});
            end else if (code >= 4 && code <= 6) begin
                a = code - 4;
                b = (a + 1) % 3;
                na = (face[a] & 'h0FFFFF) | (face[b] & 'hF00000);
                nb = (face[b] & 'h0FFFFF) | (face[a] & 'hF00000);
                face[a] = na;
                face[b] = nb;
                t++;
                m_writes.push_back('{t, 4'(a), 24'(na)});
                t++;
                m_writes.push_back('{t, 4'(b), 24'(nb)});
            end
        end
        m_lat = t + 4;
        for (int k = 0; k < 3; k++) m_face[k] = 24'(face[k]);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic load_reg(input logic [3:0] a, input logic [23:0] v);
        @(negedge clk);
        ld_en = 1'b1;
        ld_addr = a;
        ld_data = v;
        @(posedge clk);
        #1 ld_en = 1'b0;
    endtask

    // Pulse start for one cycle, then wait for done (bounded). run_lat ends
    // as the number of the DONE cycle, counting FETCH as cycle 1. When poke
    // is set, start is pulsed again while the run is busy.
    task automatic run_order(input bit poke);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_base = cyc - 1;
        run_lat = 1;
        while (!done && run_lat < 200) begin
            @(negedge clk);
            run_lat++;
            start = poke && (run_lat == 3 || run_lat == 6);
        end
        start = 1'b0;
    endtask

    task automatic do_case(input string name, input logic [23:0] f0, f1, f2,
                           input logic [23:0] i0, i1, i2, input logic [23:0] order,
                           input bit ideal_from_model, input bit poke);
        logic [23:0] id[3];
        int n;
        model(f0, f1, f2, order);
        if (ideal_from_model) begin
            id[0] = m_face[0]; id[1] = m_face[1]; id[2] = m_face[2];
        end else begin
            id[0] = i0; id[1] = i1; id[2] = i2;
        end
        m_solved = (m_face[0] == id[0]) && (m_face[1] == id[1]) && (m_face[2] == id[2]);
        load_reg(4'd0, f0);
        load_reg(4'd1, f1);
        load_reg(4'd2, f2);
        load_reg(4'd9, id[0]);
        load_reg(4'd10, id[1]);
        load_reg(4'd11, id[2]);
        load_reg(4'd6, order);
        wlog.delete();
        run_order(poke);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: done never rose within %0d cycles", name, run_lat);
        end
        checks++;
        if (run_lat != m_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d required %0d", name, run_lat, m_lat);
        end
        checks++;
        if (move_cnt !== 3'(m_cnt)) begin
            errors++;
            $display("FAIL %s move_cnt: got %0d required %0d", name, move_cnt, m_cnt);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse: done=%b busy=%b required 0/0 after DONE", name, done, busy);
        end
        checks++;
        if (solved !== m_solved) begin
            errors++;
            $display("FAIL %s solved: got %b required %b", name, solved, m_solved);
        end
        checks++;
        if (wlog.size() != m_writes.size()) begin
            errors++;
            $display("FAIL %s write_count: got %0d required %0d", name, wlog.size(), m_writes.size());
        end
        n = (wlog.size() < m_writes.size()) ? wlog.size() : m_writes.size();
        for (int j = 0; j < n; j++) begin
            checks++;
            if ((wlog[j].t - run_base) != m_writes[j].t || wlog[j].a !== m_writes[j].a ||
                wlog[j].d !== m_writes[j].d) begin
                errors++;
                $display("FAIL %s write%0d: got cyc%0d dst=%0d data=%h required cyc%0d dst=%0d data=%h",
                         name, j, wlog[j].t - run_base, wlog[j].a, wlog[j].d,
                         m_writes[j].t, m_writes[j].a, m_writes[j].d);
            end
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rf[k] !== m_face[k]) begin
                errors++;
                $display("FAIL %s face%0d: got %h required %h", name, k, rf[k], m_face[k]);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 16; i++) load_reg(4'(i), 24'd0);
        @(negedge clk);
        checks++;
        if ({busy, done, solved, we, move_cnt, src0, src1, dst, data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b solved=%b we=%b cnt=%0d src0=%0d src1=%0d dst=%0d data=%h required all 0",
                     busy, done, solved, we, move_cnt, src0, src1, dst, data);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || we !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b we=%b required 0/0", busy, we);
        end
    endtask

    task automatic test_vectors;
        // Code 1 then end: one rotate of blue.
        do_case("v034", 24'h8000C1, 24'h081408, 24'h132000, 24'h0, 24'h0, 24'h0,
                24'h1F0000, 1'b0, 1'b0);
        checks++;
        if (wlog.size() != 1 || wlog[0].a !== 4'd0 || wlog[0].d !== 24'h000C18) begin
            errors++;
            $display("FAIL v034_const: writes=%0d first dst=%0d data=%h required 1 write dst=0 data=000C18",
                     wlog.size(), wlog.size() > 0 ? wlog[0].a : 4'd0, wlog.size() > 0 ? wlog[0].d : 24'd0);
        end
        // Code 4 then end: swap the top nibble of blue and white.
        do_case("v035", 24'h8000C1, 24'h081408, 24'h132000, 24'h0, 24'h0, 24'h0,
                24'h4F0000, 1'b0, 1'b0);
        checks++;
        if (wlog.size() != 2 || wlog[0].a !== 4'd0 || wlog[0].d !== 24'h0000C1 ||
            wlog[1].a !== 4'd1 || wlog[1].d !== 24'h881408 || wlog[1].t != wlog[0].t + 1) begin
            errors++;
            $display("FAIL v035_const: writes=%0d required dst0=0000C1 then dst1=881408 on consecutive cycles",
                     wlog.size());
        end
        // Immediate end with faces equal to the ideals.
        do_case("v036", 24'hF00000, 24'h0F0000, 24'h00F000, 24'hF00000, 24'h0F0000, 24'h00F000,
                24'hF00000, 1'b0, 1'b0);
        checks++;
        if (wlog.size() != 0 || solved !== 1'b1) begin
            errors++;
            $display("FAIL v036_const: writes=%0d solved=%b required 0 writes solved=1", wlog.size(), solved);
        end
        // All NOPs: the full six READ cycles.
        do_case("v037", 24'hF00000, 24'h0F0000, 24'h00F000, 24'hF00000, 24'h0F0000, 24'h00F000,
                24'h000000, 1'b0, 1'b0);
        checks++;
        if (run_lat != 11 || move_cnt !== 3'd6 || wlog.size() != 0) begin
            errors++;
            $display("FAIL v037_const: latency=%0d cnt=%0d writes=%0d required 11/6/0",
                     run_lat, move_cnt, wlog.size());
        end
    endtask

    task automatic test_abort;
        logic [23:0] orig0, orig1;
        int n;
        checks++;
        if (solved !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre_solved: got %b required 1", solved);
        end
        load_reg(4'd6, 24'h400000);
        orig0 = rf[0];
        orig1 = rf[1];
        wlog.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!we && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (we !== 1'b1) begin
            errors++;
            $display("FAIL abort_wb0_timeout: we never rose within %0d cycles", n);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({we, busy, done, solved, move_cnt, src0, src1, dst, data} !== '0) begin
            errors++;
            $display("FAIL abort_outputs: we=%b busy=%b done=%b solved=%b cnt=%0d dst=%0d data=%h required all 0",
                     we, busy, done, solved, move_cnt, dst, data);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (wlog.size() != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_wb1: writes seen=%0d busy=%b required 1/0", wlog.size(), busy);
        end
        checks++;
        if (rf[0] !== orig0 || rf[1] !== orig1) begin
            errors++;
            $display("FAIL abort_faces: B=%h W=%h required %h %h", rf[0], rf[1], orig0, orig1);
        end
    endtask

    task automatic test_start_ignored;
        do_case("start_busy", 24'h123456, 24'h654321, 24'hABCDEF, 24'h0, 24'h0, 24'h0,
                24'h000000, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL start_busy_restart: busy=%b required 0 after run", busy);
            end
        end
    endtask

    task automatic test_random;
        logic [23:0] order;
        logic [23:0] f[3];
        for (int r = 0; r < 24; r++) begin
            order = 24'($urandom);
            for (int k = 0; k < 3; k++) f[k] = 24'($urandom);
            do_case($sformatf("rand%0d", r), f[0], f[1], f[2],
                    24'($urandom), 24'($urandom), 24'($urandom), order,
                    $urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_abort();
        test_start_ignored();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
